reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 131 +++++++++++++
 tb/tb_reset_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Debounced manual/software/global reset sources driving a
//               three-stage release sequence (bit0 first, bit2 last).
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int DEB_CYCLES  = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_btn,
    input  logic       i_sw_rst,
    output logic [2:0] o_rst_stage,
    output logic       o_busy,
    output logic [1:0] o_cause
);

    localparam int c_max_a   = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int c_max     = (c_max_a > DEB_CYCLES) ? c_max_a : DEB_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max + 1);

    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEB_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);

    localparam logic [1:0] c_cause_rst = 2'b00;
    localparam logic [1:0] c_cause_btn = 2'b01;
    localparam logic [1:0] c_cause_sw  = 2'b10;

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_REL1 = 2'd1,
        S_REL2 = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    logic [1:0]         r_sync;
    logic               r_btn_db;
    logic [c_cnt_w-1:0] r_deb_cnt;
    logic [c_cnt_w-1:0] r_cnt;
    state_t             r_state;

    logic w_btn_rise;
    logic w_trig;

    // Button path: two-flop synchroniser followed by the debounce filter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync    <= 2'b00;
            r_btn_db  <= 1'b0;
            r_deb_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            if (r_sync[1] != r_btn_db) begin
                if (r_deb_cnt == c_deb_last) begin
                    r_btn_db  <= r_sync[1];
                    r_deb_cnt <= '0;
                end else if (r_deb_cnt != c_cnt_max) begin
                    r_deb_cnt <= r_deb_cnt + c_cnt_one;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // Rising edge of the debounced level, flagged on the edge it takes effect.
    assign w_btn_rise = !r_btn_db && r_sync[1] && (r_deb_cnt == c_deb_last);
    assign w_trig     = w_btn_rise || i_sw_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            o_rst_stage <= 3'b111;
            o_busy      <= 1'b1;
            o_cause     <= c_cause_rst;
        end else if (w_trig) begin
            r_state     <= S_HOLD;
            r_cnt       <= '0;
            o_rst_stage <= 3'b111;
            o_busy      <= 1'b1;
            o_cause     <= w_btn_rise ? c_cause_btn : c_cause_sw;
        end else begin
            case (r_state)
                S_HOLD: begin
                    // A held button keeps the sequence parked at the start.
                    if (r_btn_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_hold_last) begin
                        r_state     <= S_REL1;
                        r_cnt       <= '0;
                        o_rst_stage <= 3'b110;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_REL1: begin
                    if (r_cnt == c_gap_last) begin
                        r_state     <= S_REL2;
                        r_cnt       <= '0;
                        o_rst_stage <= 3'b100;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                S_REL2: begin
                    if (r_cnt == c_gap_last) begin
                        r_state     <= S_RUN;
                        r_cnt       <= '0;
                        o_rst_stage <= 3'b000;
                        o_busy      <= 1'b0;
                    end else if (r_cnt != c_cnt_max) begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Randomised self-checking bench for reset_sequencer against a
//               timeline-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int HOLD = 16;
    localparam int GAP  = 4;
    localparam int DEB  = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       sw  = 1'b0;
    logic [2:0] rst_stage;
    logic       busy;
    logic [1:0] cause;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: raw sync samples, debounced level, run length of
    // disagreeing samples, and edges elapsed since the sequence restarted.
    int m_s0 = 0, m_s1 = 0, m_db = 0, m_run = 0, m_elapsed = 0, m_cause = 0;

    reset_sequencer #(
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .DEB_CYCLES (DEB)
    ) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_btn      (btn),
        .i_sw_rst   (sw),
        .o_rst_stage(rst_stage),
        .o_busy     (busy),
        .o_cause    (cause)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] exp_stage(input int e);
        if (e < HOLD)               return 3'b111;
        else if (e < HOLD + GAP)    return 3'b110;
        else if (e < HOLD + 2*GAP)  return 3'b100;
        else                        return 3'b000;
    endfunction

    task automatic model_edge(input logic rst_v, input logic btn_v, input logic sw_v);
        int  old_db;
        int  new_db;
        bit  rise;
        if (rst_v) begin
            m_s0 = 0; m_s1 = 0; m_db = 0; m_run = 0; m_elapsed = 0; m_cause = 0;
        end else begin
            old_db = m_db;
            new_db = m_db;
            if (m_s1 != m_db) begin
                m_run++;
                if (m_run == DEB) begin
                    new_db = m_s1;
                    m_run  = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s1 = m_s0;
            m_s0 = int'(btn_v);
            rise = (old_db == 0) && (new_db == 1);
            if (rise || sw_v) begin
                m_elapsed = 0;
                m_cause   = rise ? 1 : 2;
            end else if (m_elapsed < HOLD && old_db == 1) begin
                m_elapsed = 0;
            end else if (m_elapsed < 1000) begin
                m_elapsed++;
            end
            m_db = new_db;
        end
    endtask

    task automatic step(input logic rst_v, input logic btn_v, input logic sw_v);
        logic [2:0] es;
        @(negedge clk);
        rst = rst_v;
        btn = btn_v;
        sw  = sw_v;
        @(posedge clk);
        model_edge(rst_v, btn_v, sw_v);
        #1;
        es = exp_stage(m_elapsed);
        check_eq("stage", {5'd0, rst_stage}, {5'd0, es});
        check_eq("busy",  {7'd0, busy},      {7'd0, (es != 3'b000)});
        check_eq("cause", {6'd0, cause},     8'(m_cause));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Global reset and default release timeline, with fixed expectations.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("rst_stage", {5'd0, rst_stage}, 8'h07);
        check_eq("rst_cause", {6'd0, cause},     8'h00);
        for (int k = 1; k <= 30; k++) begin
            step(1'b0, 1'b0, 1'b0);
            if (k == 15) check_eq("rel_e15", {5'd0, rst_stage}, 8'h07);
            if (k == 16) check_eq("rel_e16", {5'd0, rst_stage}, 8'h06);
            if (k == 19) check_eq("rel_e19", {5'd0, rst_stage}, 8'h06);
            if (k == 20) check_eq("rel_e20", {5'd0, rst_stage}, 8'h04);
            if (k == 23) check_eq("rel_e23", {5'd0, rst_stage}, 8'h04);
            if (k == 24) check_eq("rel_e24", {7'd0, busy},      8'h00);
        end

        // Software pulse in RUN.
        step(1'b0, 1'b0, 1'b1);
        check_eq("sw_cause", {6'd0, cause}, 8'h02);
        idle(30);

        // Short glitch ignored, long press triggers and holds.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        idle(15);
        check_eq("glitch_run", {5'd0, rst_stage}, 8'h00);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
        check_eq("btn_cause", {6'd0, cause}, 8'h01);
        idle(45);

        // Software request on the same edge the debounced level rises.
        for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, (i == 10));
        check_eq("both_cause", {6'd0, cause}, 8'h01);
        idle(50);

        // Software held several cycles, then restart from inside REL2.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1);
        idle(21);
        step(1'b0, 1'b0, 1'b1);
        check_eq("restart", {5'd0, rst_stage}, 8'h07);
        idle(30);

        // Global reset while button held (HOLD) and then in RUN.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("midrst_cause", {6'd0, cause}, 8'h00);
        idle(30);
        step(1'b1, 1'b0, 1'b0);
        idle(30);

        // Randomised traffic.
        for (int it = 0; it < 400; it++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 9);
            n    = $urandom_range(1, 30);
            case (kind)
                0, 1, 2, 3: idle(n);
                4, 5: begin
                    n = $urandom_range(1, 40);
                    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0);
                end
                6, 7: begin
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) step(1'b0, btn, 1'b1);
                end
                8: begin
                    n = $urandom_range(1, 3);
                    for (int i = 0; i < n; i++) step(1'b1, btn, ($urandom_range(0, 1) == 1));
                end
                default: begin
                    for (int i = 0; i < n; i++)
                        step(1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
                end
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
